// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared types and constants for the operand hazard/forwarding
//               unit: scoreboard entry layout and forward-select sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int                    REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_X0     = '0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  wen;
        logic                  is_load;
    } sb_entry_t;

    // Select 0 means register file, k+1 means scoreboard entry k.
    function automatic int fwd_sel_width(input int pipe_depth);
        return $clog2(pipe_depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_port_resolve.sv
`default_nettype none
// ============================================================================
// Module      : hazard_port_resolve
// Description : Per-source-operand match, youngest-wins priority, load
//               readiness check and operand mux against the scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_port_resolve
    import riscv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int PIPE_DEPTH = 3,
    parameter int LOAD_STAGE = 1,
    parameter int SEL_W      = fwd_sel_width(PIPE_DEPTH)
) (
    input  logic [PIPE_DEPTH-1:0]            sb_valid_i,
    input  logic [PIPE_DEPTH-1:0]            sb_wen_i,
    input  logic [PIPE_DEPTH-1:0]            sb_is_load_i,
    input  logic [PIPE_DEPTH*REG_ADDR_W-1:0] sb_rd_i,
    input  logic [REG_ADDR_W-1:0]            rs_addr_i,
    input  logic                             rs_used_i,
    input  logic [XLEN-1:0]                  rf_data_i,
    input  logic [PIPE_DEPTH*XLEN-1:0]       stage_data_i,
    output logic [XLEN-1:0]                  operand_o,
    output logic [SEL_W-1:0]                 fwd_sel_o,
    output logic                             stall_req_o
);

    logic             w_hit;
    logic             w_ready;
    logic [SEL_W-1:0] w_sel;
    logic [XLEN-1:0]  w_data;

    // Scan oldest to youngest so the last hit written is the youngest producer.
    always_comb begin
        w_hit   = 1'b0;
        w_ready = 1'b0;
        w_sel   = '0;
        w_data  = '0;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            if (sb_valid_i[k] && sb_wen_i[k] && rs_used_i &&
                (rs_addr_i != REG_X0) &&
                (sb_rd_i[k*REG_ADDR_W +: REG_ADDR_W] == rs_addr_i)) begin
                w_hit   = 1'b1;
                w_ready = !sb_is_load_i[k] || (k >= LOAD_STAGE);
                w_sel   = SEL_W'(k + 1);
                w_data  = stage_data_i[k*XLEN +: XLEN];
            end
        end
    end

    assign operand_o   = (w_hit && w_ready) ? w_data : rf_data_i;
    assign fwd_sel_o   = (w_hit && w_ready) ? w_sel  : '0;
    assign stall_req_o = w_hit && !w_ready;

endmodule
`default_nettype wire

// File: rtl/riscv_hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module      : riscv_hazard_fwd_unit
// Description : Scoreboard-based operand forwarding, load-use stall and
//               flush control with saturating stall/forward counters.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_hazard_fwd_unit
    import riscv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int PIPE_DEPTH   = 3,
    parameter int LOAD_STAGE   = 1,
    parameter int CNT_W        = 32
) (
    input  logic                                          clk_100MHz,
    input  logic                                          reset,
    input  logic                                          issue_valid_i,
    input  logic [4:0]                                    issue_rd_i,
    input  logic                                          issue_wen_i,
    input  logic                                          issue_is_load_i,
    input  logic [NUM_RD_PORTS*5-1:0]                     rs_addr_i,
    input  logic [NUM_RD_PORTS-1:0]                       rs_used_i,
    input  logic [NUM_RD_PORTS*XLEN-1:0]                  rf_data_i,
    input  logic [PIPE_DEPTH*XLEN-1:0]                    stage_data_i,
    input  logic                                          flush_i,
    output logic [NUM_RD_PORTS*XLEN-1:0]                  operand_o,
    output logic [NUM_RD_PORTS*$clog2(PIPE_DEPTH+1)-1:0]  fwd_sel_o,
    output logic                                          stall_o,
    output logic [CNT_W-1:0]                              stall_cnt_o,
    output logic [CNT_W-1:0]                              fwd_cnt_o
);

    localparam int SEL_W = fwd_sel_width(PIPE_DEPTH);

    sb_entry_t                        r_sb [PIPE_DEPTH];
    logic [CNT_W-1:0]                 r_stall_cnt;
    logic [CNT_W-1:0]                 r_fwd_cnt;

    logic [PIPE_DEPTH-1:0]            w_sb_valid;
    logic [PIPE_DEPTH-1:0]            w_sb_wen;
    logic [PIPE_DEPTH-1:0]            w_sb_is_load;
    logic [PIPE_DEPTH*REG_ADDR_W-1:0] w_sb_rd;
    logic [NUM_RD_PORTS-1:0]          w_stall_req;
    logic                             w_issue_accept;
    logic                             w_any_fwd;
    sb_entry_t                        w_entry0;

    // Valid is masked during reset so the reset cycle already behaves as empty.
    generate
        for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_sb_flat
            assign w_sb_valid[k]                          = r_sb[k].valid && !reset;
            assign w_sb_wen[k]                            = r_sb[k].wen;
            assign w_sb_is_load[k]                        = r_sb[k].is_load;
            assign w_sb_rd[k*REG_ADDR_W +: REG_ADDR_W]    = r_sb[k].rd;
        end
    endgenerate

    generate
        for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
            hazard_port_resolve #(
                .XLEN       (XLEN),
                .PIPE_DEPTH (PIPE_DEPTH),
                .LOAD_STAGE (LOAD_STAGE),
                .SEL_W      (SEL_W)
            ) u_resolve (
                .sb_valid_i   (w_sb_valid),
                .sb_wen_i     (w_sb_wen),
                .sb_is_load_i (w_sb_is_load),
                .sb_rd_i      (w_sb_rd),
                .rs_addr_i    (rs_addr_i[p*REG_ADDR_W +: REG_ADDR_W]),
                .rs_used_i    (rs_used_i[p]),
                .rf_data_i    (rf_data_i[p*XLEN +: XLEN]),
                .stage_data_i (stage_data_i),
                .operand_o    (operand_o[p*XLEN +: XLEN]),
                .fwd_sel_o    (fwd_sel_o[p*SEL_W +: SEL_W]),
                .stall_req_o  (w_stall_req[p])
            );
        end
    endgenerate

    assign stall_o        = issue_valid_i && !flush_i && (|w_stall_req);
    assign w_issue_accept = issue_valid_i && !stall_o && !flush_i;
    assign w_any_fwd      = |fwd_sel_o;

    always_comb begin
        w_entry0 = '0;
        if (w_issue_accept) begin
            w_entry0.valid   = 1'b1;
            w_entry0.rd      = issue_rd_i;
            w_entry0.wen     = issue_wen_i;
            w_entry0.is_load = issue_is_load_i;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                r_sb[k] <= '0;
            end
        end else begin
            for (int k = PIPE_DEPTH - 1; k > 0; k--) begin
                r_sb[k] <= r_sb[k-1];
            end
            r_sb[0] <= w_entry0;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            if (stall_o && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_any_fwd && !stall_o && !(&r_fwd_cnt)) begin
                r_fwd_cnt <= r_fwd_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign fwd_cnt_o   = r_fwd_cnt;

endmodule
`default_nettype wire
